// File: rtl/sal_cmd_sched.sv
// -----------------------------------------------------------------------------
// sal_cmd_sched
//
// Per-channel DRAM command scheduler. Every cycle it looks at the ACT/RD/WR/PRE
// requests from all bank controllers and grants at most one of them. The grant
// is combinational, so the winning bank controller can advance in the same
// cycle. The granted command is registered onto the command bus one cycle
// later. Inter-bank timing (tRRD, tCCD, tWTR, tRTW) is enforced here.
//
// Class priority is column (RD/WR) > ACT > PRE. Within the winning class, the
// bank is picked round-robin starting at rr_ptr.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   t_rrd_m1/t_ccd_m1/
//   t_wtr_m1/t_rtw_m1           timing values minus one (sampled at load)
//   act_req/rd_req/wr_req/
//   pre_req                     per-bank request levels
//   ra_i/ca_i/id_i/len_i        packed per-bank command fields
//   act_gnt/rd_gnt/wr_gnt/
//   pre_gnt                     one-hot combinational grants (at most one bit)
//   cmd_valid_o, cmd_o,
//   cmd_ba_o ... cmd_len_o      registered command bus
// -----------------------------------------------------------------------------
module sal_cmd_sched #(
    parameter int NUM_BANKS = 4,
    parameter int BA_WIDTH  = 2,
    parameter int RA_WIDTH  = 16,
    parameter int CA_WIDTH  = 10,
    parameter int ID_WIDTH  = 4,
    parameter int LEN_WIDTH = 4,
    parameter int TW        = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [TW-1:0]                  t_rrd_m1,
    input  logic [TW-1:0]                  t_ccd_m1,
    input  logic [TW-1:0]                  t_wtr_m1,
    input  logic [TW-1:0]                  t_rtw_m1,
    input  logic [NUM_BANKS-1:0]           act_req,
    input  logic [NUM_BANKS-1:0]           rd_req,
    input  logic [NUM_BANKS-1:0]           wr_req,
    input  logic [NUM_BANKS-1:0]           pre_req,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i,
    input  logic [NUM_BANKS*LEN_WIDTH-1:0] len_i,
    output logic [NUM_BANKS-1:0]           act_gnt,
    output logic [NUM_BANKS-1:0]           rd_gnt,
    output logic [NUM_BANKS-1:0]           wr_gnt,
    output logic [NUM_BANKS-1:0]           pre_gnt,
    output logic                           cmd_valid_o,
    output logic [1:0]                     cmd_o,
    output logic [BA_WIDTH-1:0]            cmd_ba_o,
    output logic [RA_WIDTH-1:0]            cmd_ra_o,
    output logic [CA_WIDTH-1:0]            cmd_ca_o,
    output logic [ID_WIDTH-1:0]            cmd_id_o,
    output logic [LEN_WIDTH-1:0]           cmd_len_o
);

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_e;

    logic [TW-1:0]        rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BA_WIDTH-1:0]  rr_ptr;

    logic                 act_ok, rd_ok, wr_ok;
    logic [NUM_BANKS-1:0] rd_elig, wr_elig, col_elig;
    logic [NUM_BANKS-1:0] cls_req;
    cmd_e                 cls_cmd;
    logic                 sel_found;
    logic [BA_WIDTH-1:0]  sel_ba;
    cmd_e                 sel_cmd;
    logic                 issue;

    // A nonzero counter blocks its class of command.
    assign act_ok = (rrd_cnt == '0);
    assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);

    // RD and WR share one column class; each request is masked by its own
    // eligibility before the merge so an ineligible type never wins a bank.
    assign rd_elig  = rd_ok ? rd_req : '0;
    assign wr_elig  = wr_ok ? wr_req : '0;
    assign col_elig = rd_elig | wr_elig;

    // Class selection.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cls_req = pre_req;
        cls_cmd = CMD_PRE;
        if (|col_elig) begin
            cls_req = col_elig;
            cls_cmd = CMD_RD;
        end else if (act_ok && (|act_req)) begin
            cls_req = act_req;
            cls_cmd = CMD_ACT;
        end
    end

    // Round-robin bank pick: first requester at or above rr_ptr, wrapping.
    // BA_WIDTH-bit addition wraps modulo NUM_BANKS since NUM_BANKS is 2^BA_WIDTH.
    always_comb begin
        sel_found = 1'b0;
        sel_ba    = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!sel_found && cls_req[rr_ptr + BA_WIDTH'(i)]) begin
                sel_found = 1'b1;
                sel_ba    = rr_ptr + BA_WIDTH'(i);
            end
        end
    end

    // Grants. A bank asserting both RD and WR gets RD if RD is eligible.
    // Grants are forced low while reset is asserted.
    always_comb begin
        sel_cmd = cls_cmd;
        act_gnt = '0;
        rd_gnt  = '0;
        wr_gnt  = '0;
        pre_gnt = '0;
        issue   = sel_found && rst_n;
        if (cls_cmd == CMD_RD && !rd_elig[sel_ba]) begin
            sel_cmd = CMD_WR;
        end
        if (issue) begin
            case (sel_cmd)
                CMD_ACT: act_gnt[sel_ba] = 1'b1;
                CMD_RD:  rd_gnt[sel_ba]  = 1'b1;
                CMD_WR:  wr_gnt[sel_ba]  = 1'b1;
                default: pre_gnt[sel_ba] = 1'b1;
            endcase
        end
    end

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] c);
        return (c == '0) ? '0 : c - TW'(1);
    endfunction

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt     <= '0;
            ccd_cnt     <= '0;
            wtr_cnt     <= '0;
            rtw_cnt     <= '0;
            rr_ptr      <= '0;
            cmd_valid_o <= 1'b0;
            cmd_o       <= '0;
            cmd_ba_o    <= '0;
            cmd_ra_o    <= '0;
            cmd_ca_o    <= '0;
            cmd_id_o    <= '0;
            cmd_len_o   <= '0;
        end else begin
            // Load wins over decrement; timing inputs matter only at load.
            rrd_cnt <= (issue && sel_cmd == CMD_ACT) ? t_rrd_m1 : sat_dec(rrd_cnt);
            ccd_cnt <= (issue && (sel_cmd == CMD_RD || sel_cmd == CMD_WR))
                       ? t_ccd_m1 : sat_dec(ccd_cnt);
            rtw_cnt <= (issue && sel_cmd == CMD_RD) ? t_rtw_m1 : sat_dec(rtw_cnt);
            wtr_cnt <= (issue && sel_cmd == CMD_WR) ? t_wtr_m1 : sat_dec(wtr_cnt);

            cmd_valid_o <= issue;
            if (issue) begin
                rr_ptr    <= sel_ba + BA_WIDTH'(1);
                cmd_o     <= sel_cmd;
                cmd_ba_o  <= sel_ba;
                cmd_ra_o  <= ra_i[sel_ba*RA_WIDTH +: RA_WIDTH];
                cmd_ca_o  <= ca_i[sel_ba*CA_WIDTH +: CA_WIDTH];
                cmd_id_o  <= id_i[sel_ba*ID_WIDTH +: ID_WIDTH];
                cmd_len_o <= len_i[sel_ba*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

endmodule
